// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// requester A (ALU writeback) and requester B (load writeback).
module regfile_write_arbiter #(
  parameter int WORD_LENGTH      = 8,
  parameter int ADDR_WIDTH       = 3,
  parameter int ZERO_REG_PROTECT = 0,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic [ADDR_WIDTH-1:0]  a_addr,
  input  logic [WORD_LENGTH-1:0] a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [ADDR_WIDTH-1:0]  b_addr,
  input  logic [WORD_LENGTH-1:0] b_data,
  output logic                   b_ready,
  output logic                   reg_Write,
  output logic [ADDR_WIDTH-1:0]  Write_Register,
  output logic [WORD_LENGTH-1:0] Write_Data,
  output logic                   last_grant,
  output logic [CNT_WIDTH-1:0]   conflict_count
);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  req_e                   rr_ptr;
  logic                   a_xfer;
  logic                   b_xfer;
  logic                   any_xfer;
  logic                   drop_write;
  logic [ADDR_WIDTH-1:0]  gnt_addr;
  logic [WORD_LENGTH-1:0] gnt_data;

  // The pointer only matters when both requesters contend.
  always_comb begin
    // NOTE: default every output first so no path leaves one unassigned (which would infer a latch).
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_valid && (!b_valid || rr_ptr == REQ_A)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  assign a_xfer     = a_valid & a_ready;
  assign b_xfer     = b_valid & b_ready;
  assign any_xfer   = a_xfer | b_xfer;
  assign gnt_addr   = b_xfer ? b_addr : a_addr;
  assign gnt_data   = b_xfer ? b_data : a_data;
  assign drop_write = (ZERO_REG_PROTECT != 0) && (gnt_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_Write      <= 1'b0;
      Write_Register <= '0;
      Write_Data     <= '0;
      last_grant     <= 1'b0;
      conflict_count <= '0;
      rr_ptr         <= REQ_A;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      reg_Write <= any_xfer && !drop_write;
      if (any_xfer) begin
        Write_Register <= gnt_addr;
        Write_Data     <= gnt_data;
        last_grant     <= b_xfer;
        rr_ptr         <= b_xfer ? REQ_A : REQ_B;
      end
      // Saturate rather than wrap so a long stall never reads as a short one.
      if (a_valid && b_valid && conflict_count != '1) begin
        conflict_count <= conflict_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a vector table for the main grant
// and writeback behaviour, plus short sequences for saturation, zero-register
// protection and asynchronous reset.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_valid, b_valid;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;

  // Default configuration
  logic       d_a_ready, d_b_ready, d_we, d_lg;
  logic [2:0] d_wreg;
  logic [7:0] d_wdata, d_cnt;
  // CNT_WIDTH = 2
  logic       s_a_ready, s_b_ready, s_we, s_lg;
  logic [2:0] s_wreg;
  logic [7:0] s_wdata;
  logic [1:0] s_cnt;
  // ZERO_REG_PROTECT = 1
  logic       z_a_ready, z_b_ready, z_we, z_lg;
  logic [2:0] z_wreg;
  logic [7:0] z_wdata, z_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mem [8];

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(d_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(d_b_ready),
    .reg_Write(d_we), .Write_Register(d_wreg), .Write_Data(d_wdata),
    .last_grant(d_lg), .conflict_count(d_cnt)
  );

  regfile_write_arbiter #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(s_b_ready),
    .reg_Write(s_we), .Write_Register(s_wreg), .Write_Data(s_wdata),
    .last_grant(s_lg), .conflict_count(s_cnt)
  );

  regfile_write_arbiter #(.ZERO_REG_PROTECT(1)) dut_zp (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(z_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(z_b_ready),
    .reg_Write(z_we), .Write_Register(z_wreg), .Write_Data(z_wdata),
    .last_grant(z_lg), .conflict_count(z_cnt)
  );

  // Register file model: commits one edge after reg_Write is seen.
  initial for (int i = 0; i < 8; i++) mem[i] = 8'h00;
  always @(posedge clk) if (d_we) mem[d_wreg] <= d_wdata;

  // Requester protocol and grant exclusivity.
  logic       a_pend = 1'b0, b_pend = 1'b0;
  logic [2:0] pa_addr, pb_addr;
  logic [7:0] pa_data, pb_data;
  always @(posedge clk) begin
    if (!reset && a_pend)
      assert (a_valid && a_addr == pa_addr && a_data == pa_data) else $error("requester A changed before acceptance");
    if (!reset && b_pend)
      assert (b_valid && b_addr == pb_addr && b_data == pb_data) else $error("requester B changed before acceptance");
    assert (!(d_a_ready && d_b_ready)) else $error("both readys high");
    a_pend  <= !reset && a_valid && !d_a_ready;
    b_pend  <= !reset && b_valid && !d_b_ready;
    pa_addr <= a_addr; pa_data <= a_data;
    pb_addr <= b_addr; pb_data <= b_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [7:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse that starts and ends just after an edge.
  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic       av; logic [2:0] aa; logic [7:0] ad;
    logic       bv; logic [2:0] ba; logic [7:0] bd;
    logic       ea; logic       eb;
    logic       ewe; logic [2:0] ereg; logic [7:0] edata; logic elg; logic [7:0] ecnt;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            av aa    ad     bv ba    bd     ea eb we reg   data   lg cnt
    vecs[0]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd0, 8'h00, 0, 8'd0};
    vecs[1]  = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 0, 1, 3'd1, 8'h11, 0, 8'd1};
    vecs[2]  = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 1, 1, 3'd2, 8'h22, 1, 8'd2};
    vecs[3]  = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 0, 1, 3'd1, 8'h11, 0, 8'd3};
    vecs[4]  = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 1, 1, 3'd2, 8'h22, 1, 8'd4};
    vecs[5]  = '{1, 3'd1, 8'h11, 0, 3'd0, 8'h00, 1, 0, 1, 3'd1, 8'h11, 0, 8'd4};
    vecs[6]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd1, 8'h11, 0, 8'd4};
    vecs[7]  = '{1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 1, 0, 1, 3'd3, 8'h5A, 0, 8'd4};
    vecs[8]  = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'h5A, 0, 8'd4};
    vecs[9]  = '{0, 3'd0, 8'h00, 1, 3'd7, 8'hC3, 0, 1, 1, 3'd7, 8'hC3, 1, 8'd4};
    vecs[10] = '{0, 3'd0, 8'h00, 1, 3'd6, 8'h99, 0, 1, 1, 3'd6, 8'h99, 1, 8'd4};
    vecs[11] = '{1, 3'd4, 8'h44, 1, 3'd5, 8'h55, 1, 0, 1, 3'd4, 8'h44, 0, 8'd5};
    vecs[12] = '{0, 3'd0, 8'h00, 1, 3'd5, 8'h55, 0, 1, 1, 3'd5, 8'h55, 1, 8'd5};
    vecs[13] = '{1, 3'd0, 8'h01, 0, 3'd0, 8'h00, 1, 0, 1, 3'd0, 8'h01, 0, 8'd5};
    vecs[14] = '{1, 3'd3, 8'hAA, 1, 3'd3, 8'hBB, 0, 1, 1, 3'd3, 8'hBB, 1, 8'd6};
    vecs[15] = '{1, 3'd3, 8'hAA, 0, 3'd0, 8'h00, 1, 0, 1, 3'd3, 8'hAA, 0, 8'd6};
    vecs[16] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'hAA, 0, 8'd6};

    // Reset held for two edges with both requesters asserting.
    drive(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    #1 reset = 1'b1;
    #2;
    check("rst_a_ready", d_a_ready, 0);
    check("rst_b_ready", d_b_ready, 0);
    tick();
    tick();
    check("rst_we", d_we, 0);
    check("rst_cnt", d_cnt, 0);
    reset = 1'b0;
    drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);

    for (int i = 0; i < 10; i++) begin
      #2;
      check("idle_ready", {d_a_ready, d_b_ready}, 2'b00);
      tick();
      check("idle_we", d_we, 0);
      check("idle_cnt", d_cnt, 0);
    end

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
      #2;
      check($sformatf("v%0d_a_ready", i), d_a_ready, vecs[i].ea);
      check($sformatf("v%0d_b_ready", i), d_b_ready, vecs[i].eb);
      tick();
      check($sformatf("v%0d_we", i), d_we, vecs[i].ewe);
      check($sformatf("v%0d_wreg", i), d_wreg, vecs[i].ereg);
      check($sformatf("v%0d_wdata", i), d_wdata, vecs[i].edata);
      check($sformatf("v%0d_last_grant", i), d_lg, vecs[i].elg);
      check($sformatf("v%0d_cnt", i), d_cnt, vecs[i].ecnt);
    end
    check("rf_same_addr_later_wins", mem[3], 8'hAA);
    check("rf_addr5", mem[5], 8'h55);

    // Async reset right after a transfer to register 5: the write is lost.
    drive(1, 3'd5, 8'h77, 0, 3'd0, 8'h00);
    tick();
    check("ar_we_before", d_we, 1);
    check("ar_wreg_before", d_wreg, 5);
    drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    #1 reset = 1'b1;
    #1;
    check("ar_we_async", d_we, 0);
    check("ar_wreg_async", d_wreg, 0);
    check("ar_wdata_async", d_wdata, 0);
    check("ar_cnt_async", d_cnt, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("ar_rf5_unchanged", mem[5], 8'h55);
    drive(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    #2;
    check("ar_ptr_a_ready", d_a_ready, 1);
    check("ar_ptr_b_ready", d_b_ready, 0);
    tick();
    check("ar_first_grant", d_wreg, 1);
    drive(0, 3'd0, 8'h00, 1, 3'd2, 8'h22);
    tick();
    check("ar_second_grant", d_wreg, 2);
    drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    tick();

    // Two-bit counter saturates at 3.
    pulse_reset();
    drive(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("sat_cnt%0d", i), s_cnt, (i < 3) ? i + 1 : 3);
    end
    drive(1, 3'd1, 8'h11, 0, 3'd0, 8'h00);
    tick();
    check("sat_hold", s_cnt, 3);
    drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    tick();

    // Zero-register protection.
    pulse_reset();
    drive(0, 3'd0, 8'h00, 1, 3'd0, 8'hFF);
    #2;
    check("zp_b_ready", z_b_ready, 1);
    tick();
    check("zp_b_we", z_we, 0);
    check("zp_b_last_grant", z_lg, 1);
    drive(1, 3'd0, 8'h12, 0, 3'd0, 8'h00);
    #2;
    check("zp_a_ready", z_a_ready, 1);
    tick();
    check("zp_a_we", z_we, 0);
    check("zp_a_last_grant", z_lg, 0);
    drive(0, 3'd0, 8'h00, 1, 3'd2, 8'h34);
    tick();
    check("zp_nonzero_we", z_we, 1);
    check("zp_nonzero_wreg", z_wreg, 2);
    check("zp_nonzero_wdata", z_wdata, 8'h34);
    drive(0, 3'd0, 8'h00, 0, 3'd0, 8'h00);
    tick();
    check("zp_idle_we", z_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
